// File: rtl/enc_serial.sv
// Sequential multi-hot to binary encoder: captures a request vector, then hands out
// the index of each set bit (lowest first) over a valid/ready interface.
module enc_serial #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e,
    input  logic         load,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         busy,
    output logic [W:0]   left,
    output logic         multi,
    output logic         none,
    output logic         dbg_state
);

    // Handshake: an index transfers on every cycle where valid && ready are both
    // high; valid, once raised, stays high with y stable until that transfer.
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [W:0]     left_q, left_d;
    logic           multi_q, multi_d;
    logic           none_q, none_d;
    logic [W-1:0]   cur_idx;
    logic [W:0]     req_cnt;

    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Scanning from the top lets the lowest set bit overwrite any higher ones.
    function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        left_d  = left_q;
        multi_d = multi_q;
        none_d  = 1'b0;
        cur_idx = lowest(pend_q);
        req_cnt = popcount(req);

        case (state_q)
            IDLE: begin
                if (load && e) begin
                    pend_d  = req;
                    multi_d = (req_cnt > (W+1)'(1));
                    if (req != '0) begin
                        state_d = SERVE;
                        left_d  = req_cnt;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (ready) begin
                    // v & (v - 1) drops exactly the lowest set bit.
                    pend_d = pend_q & (pend_q - N'(1));
                    left_d = left_q - (W+1)'(1);
                    if (pend_d == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            left_q  <= '0;
            multi_q <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            left_q  <= left_d;
            multi_q <= multi_d;
            none_q  <= none_d;
        end
    end

    assign valid     = (state_q == SERVE);
    assign busy      = (state_q == SERVE);
    assign y         = (state_q == SERVE) ? cur_idx : '0;
    assign left      = left_q;
    assign multi     = multi_q;
    assign none      = none_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_enc_serial.sv
// Self-checking bench for enc_serial: directed scenarios plus randomized vectors
// checked against a queue-of-indices reference model.
module tb_enc_serial;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic         e;
    logic         load;
    logic [N-1:0] req;
    logic         ready;
    logic [W-1:0] y;
    logic         valid;
    logic         busy;
    logic [W:0]   left;
    logic         multi;
    logic         none;
    logic         dbg_state;

    int checks;
    int errors;

    enc_serial #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .e(e), .load(load), .req(req), .ready(ready),
        .y(y), .valid(valid), .busy(busy), .left(left), .multi(multi),
        .none(none), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [N-1:0] v);
        e = 1'b1; load = 1'b1; req = v;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; e = 1'b1; req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({valid, busy, left, multi, none} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d valid=%b busy=%b left=%0d multi=%b none=%b want all 0",
                         i, valid, busy, left, multi, none);
            end
        end
        rst = 1'b0; load = 1'b0;
        step();
        checks++;
        if ({valid, busy, left, multi, none} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release valid=%b busy=%b left=%0d multi=%b none=%b want all 0",
                     valid, busy, left, multi, none);
        end
    endtask

    task automatic test_single();
        ready = 1'b1;
        capture(4'b0100);
        checks++;
        if ({valid, busy, y, left, multi} !== {1'b1, 1'b1, 2'd2, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_serve valid=%b busy=%b y=%0d left=%0d multi=%b want 1 1 2 1 0",
                     valid, busy, y, left, multi);
        end
        step();
        checks++;
        if ({valid, busy, left} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL single_done valid=%b busy=%b left=%0d want 0 0 0", valid, busy, left);
        end
    endtask

    task automatic test_multi_drain();
        logic [W-1:0] exp_y [3];
        exp_y[0] = 2'd0; exp_y[1] = 2'd1; exp_y[2] = 2'd3;
        ready = 1'b1;
        capture(4'b1011);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valid, y, left, multi} !== {1'b1, exp_y[i], 3'(3 - i), 1'b1}) begin
                errors++;
                $display("FAIL multi_drain%0d valid=%b y=%0d left=%0d multi=%b want 1 %0d %0d 1",
                         i, valid, y, left, multi, exp_y[i], 3 - i);
            end
            step();
        end
        checks++;
        if ({valid, busy, left} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL multi_end valid=%b busy=%b left=%0d want 0 0 0", valid, busy, left);
        end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        capture(4'b0110);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({valid, y, left} !== {1'b1, 2'd1, 3'd2}) begin
                errors++;
                $display("FAIL bp_hold%0d valid=%b y=%0d left=%0d want 1 1 2", i, valid, y, left);
            end
            if (i < 3) step();
        end
        ready = 1'b1;
        step();
        checks++;
        if ({valid, y, left} !== {1'b1, 2'd2, 3'd1}) begin
            errors++;
            $display("FAIL bp_second valid=%b y=%0d left=%0d want 1 2 1", valid, y, left);
        end
        step();
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bp_end valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_zero_and_enable();
        e = 1'b0; load = 1'b1; req = 4'b0001;
        step();
        load = 1'b0; e = 1'b1;
        checks++;
        if ({valid, busy, none} !== 3'b000) begin
            errors++;
            $display("FAIL e_gate valid=%b busy=%b none=%b want 0 0 0", valid, busy, none);
        end
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL e_gate_late valid=%b want 0", valid);
        end
        // multi is 1 from the previous vector; a zero capture must clear it
        capture(4'b0000);
        checks++;
        if ({none, busy, valid, multi, left} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL zero_cap none=%b busy=%b valid=%b multi=%b left=%0d want 1 0 0 0 0",
                     none, busy, valid, multi, left);
        end
        step();
        checks++;
        if ({none, busy} !== 2'b00) begin
            errors++;
            $display("FAIL zero_pulse none=%b busy=%b want 0 0", none, busy);
        end
    endtask

    task automatic test_ignore_and_abort();
        ready = 1'b0;
        capture(4'b1100);
        load = 1'b1; req = 4'b0001;
        checks++;
        if ({valid, y, left} !== {1'b1, 2'd2, 3'd2}) begin
            errors++;
            $display("FAIL ign_first valid=%b y=%0d left=%0d want 1 2 2", valid, y, left);
        end
        step();
        ready = 1'b1;
        step();
        checks++;
        if ({valid, y, left} !== {1'b1, 2'd3, 3'd1}) begin
            errors++;
            $display("FAIL ign_second valid=%b y=%0d left=%0d want 1 3 1", valid, y, left);
        end
        step();
        load = 1'b0;
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ign_end valid=%b busy=%b want 0 0", valid, busy);
        end
        step();
        // abort after the first handshake
        capture(4'b0111);
        step();
        checks++;
        if ({valid, y, left} !== {1'b1, 2'd1, 3'd2}) begin
            errors++;
            $display("FAIL abort_pre valid=%b y=%0d left=%0d want 1 1 2", valid, y, left);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({valid, busy, left, multi} !== {1'b0, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_rst valid=%b busy=%b left=%0d multi=%b want 0 0 0 0",
                     valid, busy, left, multi);
        end
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_after valid=%b want 0", valid);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q[$];
        logic [N-1:0] v;
        int budget;
        for (int t = 0; t < 30; t++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            exp_q.delete();
            for (int b = 0; b < N; b++) if (v[b]) exp_q.push_back(W'(b));
            ready = 1'b0;
            capture(v);
            checks++;
            if (multi !== (exp_q.size() > 1)) begin
                errors++;
                $display("FAIL rnd_multi vec=%b multi=%b want %b", v, multi, exp_q.size() > 1);
            end
            budget = 0;
            while (exp_q.size() > 0 && budget < 200) begin
                checks++;
                if ({valid, busy, y, left} !== {1'b1, 1'b1, exp_q[0], (W+1)'(exp_q.size())}) begin
                    errors++;
                    $display("FAIL rnd_serve vec=%b valid=%b busy=%b y=%0d left=%0d want 1 1 %0d %0d",
                             v, valid, busy, y, left, exp_q[0], exp_q.size());
                end
                ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    load = 1'b1; req = N'($urandom);
                end else begin
                    load = 1'b0;
                end
                step();
                if (ready) void'(exp_q.pop_front());
                budget++;
            end
            load = 1'b0;
            if (budget >= 200) begin
                errors++;
                $display("FAIL rnd_timeout vec=%b remaining=%0d", v, exp_q.size());
            end
            checks++;
            if ({valid, busy, left} !== {1'b0, 1'b0, 3'd0}) begin
                errors++;
                $display("FAIL rnd_end vec=%b valid=%b busy=%b left=%0d want 0 0 0",
                         v, valid, busy, left);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; e = 1'b0; load = 1'b0; req = '0; ready = 1'b0;
        test_reset();
        test_single();
        test_multi_drain();
        test_backpressure();
        test_zero_and_enable();
        test_ignore_and_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
